// File: rtl/stack_ctl_if.sv
// Bundle of core, host, stack-memory and status signals around one j1a stack.
// The controller connects through the slave modport; the environment drives the master side.
interface stack_ctl_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 5
);
    logic             cpu_push;
    logic             cpu_pop;
    logic [WIDTH-1:0] cpu_d;
    logic             cpu_clear;
    logic             cpu_stall;

    logic             host_req;
    logic             host_push;
    logic [WIDTH-1:0] host_d;
    logic             host_ack;
    logic [WIDTH-1:0] host_rdata;
    logic             host_err;

    logic             stk_push;
    logic             stk_pop;
    logic             stk_reset;
    logic [WIDTH-1:0] stk_d;
    logic [WIDTH-1:0] stk_q;

    logic [DEPTH:0]   depth;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             unf;
    logic             err_clr;

    modport master (
        output cpu_push, cpu_pop, cpu_d, cpu_clear,
        output host_req, host_push, host_d,
        output stk_q, err_clr,
        input  cpu_stall, host_ack, host_rdata, host_err,
        input  stk_push, stk_pop, stk_reset, stk_d,
        input  depth, full, empty, ovf, unf
    );

    modport slave (
        input  cpu_push, cpu_pop, cpu_d, cpu_clear,
        input  host_req, host_push, host_d,
        input  stk_q, err_clr,
        output cpu_stall, host_ack, host_rdata, host_err,
        output stk_push, stk_pop, stk_reset, stk_d,
        output depth, full, empty, ovf, unf
    );
endinterface

// File: rtl/stack_ctl.sv
// Depth tracking, core/host arbitration and clear sequencing for one j1a stack.
// Define STACK_CTL_CHECK_EN to suppress overflowing/underflowing operations and raise ovf/unf/host_err.
module stack_ctl #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 5,
    parameter int STARVE = 4
) (
    input  logic        clk,
    input  logic        reset,
    stack_ctl_if.slave  bus
);
    localparam int              CAP      = 2 ** DEPTH;
    localparam logic [DEPTH:0]  CAP_V    = (DEPTH + 1)'(CAP);
    localparam logic [DEPTH:0]  ONE_V    = (DEPTH + 1)'(1);
    localparam int              CNT_W    = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [CNT_W-1:0] STARVE_V = CNT_W'(STARVE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t           state_reg;
    logic [DEPTH:0]   depth_reg;
    logic [DEPTH:0]   depth_next;
    logic [CNT_W-1:0] wait_reg;
    logic [CNT_W-1:0] wait_next;
    logic             stk_reset_reg;
    logic             ovf_reg;
    logic             unf_reg;
    logic             host_ack_reg;
    logic             host_err_reg;
    logic [WIDTH-1:0] host_rdata_reg;
    logic             hpush_reg;
    logic [WIDTH-1:0] hd_reg;

    logic core_ok;
    logic core_push;
    logic core_pop;
    logic host_act;
    logic req_push;
    logic req_pop;
    logic block_push;
    logic block_pop;
    logic fwd_push;
    logic fwd_pop;
    logic grant;

    always_comb begin
        // The core owns the port except while the stack is clearing or the host op is issued.
        core_ok   = !stk_reset_reg && (state_reg != ISSUE);
        core_push = bus.cpu_push && core_ok;
        core_pop  = bus.cpu_pop && !bus.cpu_push && core_ok;
        host_act  = (state_reg == ISSUE) && !stk_reset_reg;
        req_push  = host_act ? hpush_reg  : core_push;
        req_pop   = host_act ? !hpush_reg : core_pop;
`ifdef STACK_CTL_CHECK_EN
        block_push = req_push && (depth_reg == CAP_V);
        block_pop  = req_pop && (depth_reg == '0);
`else
        block_push = 1'b0;
        block_pop  = 1'b0;
`endif
        fwd_push = req_push && !block_push;
        fwd_pop  = req_pop && !block_pop;

        // A pending clear also blocks the grant so the host op never lands on a resetting stack.
        grant = (state_reg == IDLE) && bus.host_req && !stk_reset_reg && !bus.cpu_clear &&
                (!(bus.cpu_push || bus.cpu_pop) || (wait_reg == STARVE_V));

        depth_next = depth_reg;
        if (bus.cpu_clear) begin
            depth_next = '0;
        end else if (fwd_push) begin
            depth_next = depth_reg + ONE_V;
        end else if (fwd_pop) begin
            depth_next = depth_reg - ONE_V;
        end

        wait_next = '0;
        if ((state_reg == IDLE) && bus.host_req && !grant) begin
            wait_next = (wait_reg == STARVE_V) ? wait_reg : wait_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_reg     <= '0;
            stk_reset_reg <= 1'b1;
            ovf_reg       <= 1'b0;
            unf_reg       <= 1'b0;
            wait_reg      <= '0;
        end else begin
            depth_reg     <= depth_next;
            stk_reset_reg <= bus.cpu_clear;
            // A fresh error outranks a simultaneous clear request.
            ovf_reg       <= block_push || (ovf_reg && !bus.err_clr);
            unf_reg       <= block_pop  || (unf_reg && !bus.err_clr);
            wait_reg      <= wait_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            host_ack_reg   <= 1'b0;
            host_err_reg   <= 1'b0;
            host_rdata_reg <= '0;
            hpush_reg      <= 1'b0;
            hd_reg         <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    host_ack_reg <= 1'b0;
                    host_err_reg <= 1'b0;
                    if (grant) begin
                        state_reg <= ISSUE;
                        hpush_reg <= bus.host_push;
                        hd_reg    <= bus.host_d;
                    end
                end
                ISSUE: begin
                    // stk_q still shows the pre-operation top here, i.e. the popped word.
                    state_reg      <= ACK;
                    host_ack_reg   <= 1'b1;
                    host_rdata_reg <= bus.stk_q;
                    host_err_reg   <= block_push || block_pop;
                end
                ACK: begin
                    state_reg    <= IDLE;
                    host_ack_reg <= 1'b0;
                    host_err_reg <= 1'b0;
                end
                default: begin
                    state_reg    <= IDLE;
                    host_ack_reg <= 1'b0;
                    host_err_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_stall  = (state_reg == ISSUE) || stk_reset_reg;
    assign bus.stk_push   = fwd_push;
    assign bus.stk_pop    = fwd_pop;
    assign bus.stk_d      = host_act ? hd_reg : bus.cpu_d;
    assign bus.stk_reset  = stk_reset_reg;
    assign bus.host_ack   = host_ack_reg;
    assign bus.host_rdata = host_rdata_reg;
    assign bus.host_err   = host_err_reg;
    assign bus.depth      = depth_reg;
    assign bus.full       = (depth_reg == CAP_V);
    assign bus.empty      = (depth_reg == '0);
    assign bus.ovf        = ovf_reg;
    assign bus.unf        = unf_reg;
endmodule

// File: tb/tb_stack_ctl.sv
// Directed bench for stack_ctl with a behavioural stack memory and a host-result scoreboard.
module tb_stack_ctl;
    localparam int WIDTH  = 16;
    localparam int DEPTH  = 5;
    localparam int STARVE = 4;
    localparam int CAP    = 32;
`ifdef STACK_CTL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stack_ctl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stack_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural stack: q shows the top of stack and updates on the strobe edge.
    logic [WIDTH-1:0] mem [0:127];
    logic [6:0]       sp = '0;
    logic [WIDTH-1:0] q  = '0;
    assign bus.stk_q = q;
    always @(posedge clk) begin
        if (bus.stk_reset) begin
            sp <= '0;
            q  <= '0;
        end else if (bus.stk_push) begin
            mem[sp] <= bus.stk_d;
            sp      <= sp + 7'd1;
            q       <= bus.stk_d;
        end else if (bus.stk_pop) begin
            sp <= sp - 7'd1;
            q  <= (sp >= 7'd2) ? mem[sp - 7'd2] : '0;
        end
    end

    typedef struct packed {
        logic [WIDTH-1:0] rdata;
        logic             err;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic core_push(input logic [WIDTH-1:0] d, input logic exp_strobe);
        bus.cpu_push = 1'b1;
        bus.cpu_d    = d;
        settle();
        chk("core_stk_push", bus.stk_push, exp_strobe);
        if (exp_strobe) chk("core_stk_d", bus.stk_d, d);
        tick();
        bus.cpu_push = 1'b0;
    endtask

    task automatic do_clear();
        bus.cpu_clear = 1'b1;
        tick();
        bus.cpu_clear = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.host_ack === 1'b1) begin
            $display("host ack: rdata=0x%04h err=%0b pending=%0d", bus.host_rdata, bus.host_err, sb.size());
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_ack observed=ack expected=no_ack");
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("host_rdata", bus.host_rdata, e.rdata);
                chk("host_err", bus.host_err, e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cpu_push  = 1'b0;
        bus.cpu_pop   = 1'b0;
        bus.cpu_d     = '0;
        bus.cpu_clear = 1'b0;
        bus.host_req  = 1'b0;
        bus.host_push = 1'b0;
        bus.host_d    = '0;
        bus.err_clr   = 1'b0;

        // Reset state and release
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        settle();
        chk("rst_stk_reset", bus.stk_reset, 1);
        chk("rst_cpu_stall", bus.cpu_stall, 1);
        chk("rst_depth", bus.depth, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_host_ack", bus.host_ack, 0);
        chk("rst_host_rdata", bus.host_rdata, 0);
        chk("rst_flags", {bus.ovf, bus.unf, bus.host_err}, 0);
        tick();
        chk("rel_stk_reset", bus.stk_reset, 0);
        chk("rel_cpu_stall", bus.cpu_stall, 0);
        core_push(16'h1111, 1'b1);
        chk("depth_after_1", bus.depth, 1);
        core_push(16'h2222, 1'b1);
        chk("depth_after_2", bus.depth, 2);

        // Host read-back with idle core
        do_clear();
        core_push(16'hAAAA, 1'b1);
        core_push(16'hBBBB, 1'b1);
        bus.host_req  = 1'b1;
        bus.host_push = 1'b0;
        sb.push_back('{rdata: 16'hBBBB, err: 1'b0});
        settle();
        chk("rb_grant_stall", bus.cpu_stall, 0);
        tick();
        settle();
        chk("rb_issue_stall", bus.cpu_stall, 1);
        chk("rb_issue_pop", bus.stk_pop, 1);
        chk("rb_issue_ack", bus.host_ack, 0);
        tick();
        bus.host_req = 1'b0;
        settle();
        chk("rb_ack", bus.host_ack, 1);
        chk("rb_depth", bus.depth, 1);
        tick();
        chk("rb_sb_drained", sb.size(), 0);
        chk("rb_ack_done", bus.host_ack, 0);

        // Clear at depth 7 with a push held into the clear cycle
        for (int i = 0; i < 6; i++) core_push(16'h0100 + 16'(i), 1'b1);
        chk("clr_depth7", bus.depth, 7);
        bus.cpu_clear = 1'b1;
        tick();
        bus.cpu_clear = 1'b0;
        bus.cpu_push  = 1'b1;
        bus.cpu_d     = 16'h3333;
        settle();
        chk("clr_depth0", bus.depth, 0);
        chk("clr_stk_reset", bus.stk_reset, 1);
        chk("clr_stall", bus.cpu_stall, 1);
        chk("clr_no_push", bus.stk_push, 0);
        tick();
        settle();
        chk("clr_push_after", bus.stk_push, 1);
        tick();
        bus.cpu_push = 1'b0;
        chk("clr_depth_after", bus.depth, 1);

        // Starvation: core pushes every cycle while the host waits to pop
        do_clear();
        bus.host_req  = 1'b1;
        bus.host_push = 1'b0;
        sb.push_back('{rdata: 16'h5004, err: 1'b0});
        bus.cpu_push = 1'b1;
        for (int i = 0; i < STARVE + 1; i++) begin
            bus.cpu_d = 16'h5000 + 16'(i);
            settle();
            chk("stv_idle_stall", bus.cpu_stall, 0);
            chk("stv_idle_push", bus.stk_push, 1);
            tick();
        end
        bus.cpu_d = 16'h5005;
        settle();
        chk("stv_issue_stall", bus.cpu_stall, 1);
        chk("stv_issue_pop", bus.stk_pop, 1);
        chk("stv_issue_nopush", bus.stk_push, 0);
        chk("stv_depth5", bus.depth, 5);
        tick();
        bus.host_req = 1'b0;
        bus.cpu_push = 1'b0;
        settle();
        chk("stv_ack_stall", bus.cpu_stall, 0);
        chk("stv_ack", bus.host_ack, 1);
        chk("stv_depth4", bus.depth, 4);
        tick();
        chk("stv_sb_drained", sb.size(), 0);

        // Capacity boundary
        do_clear();
        for (int i = 0; i < CAP; i++) core_push(16'h6000 + 16'(i), 1'b1);
        chk("bnd_full", bus.full, 1);
        core_push(16'h6FFF, !CHK);
        chk("bnd_ovf", bus.ovf, 32'(CHK));
        chk("bnd_full_after", bus.full, 32'(CHK));
        chk("bnd_depth", bus.depth, CHK ? 32 : 33);

        do_clear();
        bus.cpu_pop = 1'b1;
        settle();
        chk("unf_pop_strobe", bus.stk_pop, 32'(!CHK));
        tick();
        chk("unf_flag", bus.unf, 32'(CHK));
        chk("unf_depth", bus.depth, CHK ? 0 : 63);
        bus.err_clr = 1'b1;
        tick();
        bus.cpu_pop = 1'b0;
        chk("errclr_race_unf", bus.unf, 32'(CHK));
        chk("errclr_race_ovf", bus.ovf, 0);
        tick();
        bus.err_clr = 1'b0;
        chk("errclr_flags", {bus.ovf, bus.unf}, 0);

        // Host pop at empty
        do_clear();
        bus.host_req  = 1'b1;
        bus.host_push = 1'b0;
        sb.push_back('{rdata: 16'h0000, err: CHK});
        tick();
        settle();
        chk("hemp_issue_pop", bus.stk_pop, 32'(!CHK));
        tick();
        bus.host_req = 1'b0;
        tick();
        chk("hemp_sb_drained", sb.size(), 0);
        chk("hemp_unf", bus.unf, 32'(CHK));
        chk("hemp_depth", bus.depth, CHK ? 0 : 63);

        // Asynchronous reset while the host op is being issued
        do_clear();
        core_push(16'h7777, 1'b1);
        bus.host_req  = 1'b1;
        bus.host_push = 1'b0;
        tick();
        settle();
        chk("ar_issue_stall", bus.cpu_stall, 1);
        #1 reset = 1'b1;
        bus.host_req = 1'b0;
        #1;
        chk("ar_depth", bus.depth, 0);
        chk("ar_ack", bus.host_ack, 0);
        chk("ar_no_pop", bus.stk_pop, 0);
        chk("ar_stk_reset", bus.stk_reset, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ar_no_ack", bus.host_ack, 0);
            tick();
        end
        chk("ar_depth_after", bus.depth, 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
